// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the round-robin shared-adder arbiter.
// Imported by the top level and the priority selector.
package adder_arbiter_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREQ_MAX  = 8;
  localparam int PTR_W     = 3;
  localparam logic [7:0] BUSY_MAX = 8'd255;

  // Lowest bit of requester i's slice in a flattened NREQ*w bus.
  function automatic int slice_lo(input int i, input int w);
    return i * w;
  endfunction

  function automatic int unsigned popcount(input logic [NREQ_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/Adder.sv
// Shared combinational adder; the carry out is discarded so sums wrap modulo 2^WIDTH.
module Adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin selector: the first eligible index after rr_ptr wins.
module adder_arbiter_rr_pick
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  // Scan NREQ positions starting one past the last winner, wrapping around.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_any && elig[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = PTR_W'(idx);
      end else begin
        grant_any      = grant_any;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one Adder between NREQ requesters; each owns a one-entry result slot
// with valid/ready backpressure and receives its sum one cycle after the grant.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic [NREQ*WIDTH-1:0] resp_res,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [7:0]            busy_cnt
);

  logic [NREQ-1:0]     elig;
  logic [NREQ_MAX-1:0] elig_ext;
  logic [NREQ-1:0]     grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  logic [PTR_W-1:0]    rr_ptr;
  logic [WIDTH-1:0]    add_a;
  logic [WIDTH-1:0]    add_b;
  logic [WIDTH-1:0]    add_sum;
  logic                contention;

  // A requester may win only if its slot is free or is being drained this cycle.
  always_comb begin
    elig     = req_valid & (~resp_valid | resp_ready);
    elig_ext = '0;
    elig_ext[NREQ-1:0] = elig;
    contention = (popcount(elig_ext) > 1);
  end

  adder_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Gate with rst_n so no handshake can complete while reset is held.
  always_comb begin
    if (rst_n) begin
      req_ready = grant;
    end else begin
      req_ready = '0;
    end
  end

  // Operand mux from the granted requester; zero when idle.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        add_a = req_op1[slice_lo(i, WIDTH) +: WIDTH];
        add_b = req_op2[slice_lo(i, WIDTH) +: WIDTH];
      end else begin
        add_a = add_a;
        add_b = add_b;
      end
    end
  end

  Adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  // Round-robin pointer follows the most recent winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PTR_W'(NREQ - 1);
    end else if (grant_any) begin
      rr_ptr <= grant_idx;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  // Result slots: a grant (re)fills the slot even if it is being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_res   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          resp_valid[i] <= 1'b1;
          resp_res[slice_lo(i, WIDTH) +: WIDTH] <= add_sum;
        end else if (resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end else begin
          resp_valid[i] <= resp_valid[i];
        end
      end
    end
  end

  // Contention statistic, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 8'd0;
    end else if (contention && (busy_cnt != BUSY_MAX)) begin
      busy_cnt <= busy_cnt + 8'd1;
    end else begin
      busy_cnt <= busy_cnt;
    end
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Round-robin arbiter sharing one instance of the 32-bit combinational `Adder` between NREQ requesters (e.g. PC+4, branch-target, AGU, debug). Each requester presents an operand pair with a valid/ready handshake. It receives its sum one cycle later in a private response register, with backpressure. The block sits in the datapath wherever several address/sum consumers would otherwise each need a dedicated adder.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width; must equal the `Adder` width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_op1  input  NREQ*WIDTH  flattened first operands; requester i occupies bits [i*WIDTH +: WIDTH]
req_op2  input  NREQ*WIDTH  flattened second operands, same packing
req_ready  output  NREQ  one-hot (or zero) grant; handshake completes when req_valid[i] && req_ready[i]
resp_valid  output  NREQ  per-requester result valid
resp_res  output  NREQ*WIDTH  flattened per-requester results, same packing
resp_ready  input  NREQ  per-requester result accepted
busy_cnt  output  8  saturating count of cycles with at least one eligible requester not granted (contention statistic)

Behaviour:
- Reset (async, rst_n=0): resp_valid=0, resp_res=0, busy_cnt=0, rr_ptr=NREQ-1. req_ready is combinational and must be 0 while rst_n=0.
- Slot state per requester: EMPTY (resp_valid=0) or FULL (resp_valid=1).
  - FULL -> EMPTY when resp_ready[i]=1.
  - EMPTY/FULL -> FULL when granted.
  - Grant and consume in the same cycle: slot stays FULL and loads the new result.
- Eligibility: elig[i] = req_valid[i] && (!resp_valid[i] || resp_ready[i]).
- Arbitration (combinational):
  - Search elig starting at index rr_ptr+1 mod NREQ, wrapping.
  - The first eligible index gets req_ready[i]=1; all others get 0.
  - At most one grant per cycle.
  - No eligible requester -> req_ready=0.
- Datapath:
  - The shared `Adder` op1/op2 are muxed from the granted requester. When idle they are driven to 0.
  - On grant, resp_res[i] <= res at the clock edge, giving 1-cycle latency from handshake to resp_valid.
  - Sum is modulo 2^WIDTH; carry is discarded (FFFFFFFF+1=0).
  - Ungranted resp_res slots hold their value.
- rr_ptr: updates to the granted index on each grant; unchanged when idle. This guarantees any continuously eligible requester is granted within NREQ cycles.
- Operands must be stable only in the handshake cycle. The arbiter never stores them beyond the sum.
- req_ready may depend on req_valid and resp_ready (Mealy). Requesters must not make req_valid depend on req_ready.
- busy_cnt increments when popcount(elig) > 1, i.e. some eligible requester is denied. It saturates at 255 and never wraps.
- Reset asserted mid-operation: pending results are dropped, resp_valid clears immediately, and arbitration restarts at index 0.

Decomposition:
- Shared package: WIDTH default, NREQ max, and helper constant for the flattened bus slice width.
- Sub-module `rr_pick`: pure combinational round-robin priority selector (elig, rr_ptr -> one-hot grant, grant index).
- Reuse the existing `Adder` unchanged as the single arithmetic instance.

Test Plan:
- Single request: req0 op1=15, op2=10 with all resp_ready=1 -> req_ready[0]=1 same cycle; next cycle resp_valid[0]=1, resp_res[0]=25; busy_cnt=0.
- Wrap-around: req2 op1=32'hFFFFFFFF, op2=1 -> resp_res[2]=0 after 1 cycle; req3 op1=123456789, op2=987654321 -> 1111111110.
- Contention: all four req_valid=1 continuously, resp_ready=1 -> grants in order 0,1,2,3,0; every requester is served exactly once per 4 cycles; busy_cnt increments on each of the first three cycles (popcount(elig)>1) and keeps counting while contention persists.
- Backpressure: resp_ready[1]=0 with resp_valid[1]=1 and req_valid[1]=1 -> requester 1 is never granted and resp_res[1] holds. Raising resp_ready[1] allows a grant that same cycle, and the new result appears the next cycle.
- Saturation: hold 2 requesters eligible for 300 cycles -> busy_cnt stops at 255.
- Async reset: drop rst_n mid-burst between edges -> resp_valid=0 and req_ready=0 immediately. After release, with all requesting, the first grant goes to requester 0.
